// File: rtl/dac_ch_scheduler.sv
// dac_ch_scheduler
//   Shares one 4-channel TLC5620 serial DAC driver between four independent
//   requesters. Each channel keeps a shadow value and a pending flag; at every
//   driver frame boundary one pending channel is picked round-robin and its
//   command word is presented to the driver for the whole next frame.
//
// Ports
//   clk        system clock (shared with the DAC driver)
//   rst        synchronous reset, active-high
//   frame_tick one-cycle pulse in the driver's last frame cycle
//   req        per-channel write request (bit i = channel i)
//   req_data   channel i data on bits [DW*i+DW-1:DW*i]
//   req_rng    channel i range bit (0 = 1x, 1 = 2x)
//   cmd        command word {ch[1:0], rng, data[DW-1:0]} to the driver
//   grant      one-hot pulse: channel latched into cmd
//   done       one-hot pulse: granted channel's frame finished
//   pending    current pending flags
//   busy       high while a granted frame is in flight
module dac_ch_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic [NCH-1:0]      req,
    input  logic [NCH*DW-1:0]   req_data,
    input  logic [NCH-1:0]      req_rng,
    output logic [DW+2:0]       cmd,
    output logic [NCH-1:0]      grant,
    output logic [NCH-1:0]      done,
    output logic [NCH-1:0]      pending,
    output logic                busy
);

    logic [DW-1:0]  shadow_data [NCH];
    logic [NCH-1:0] shadow_rng;
    logic [1:0]     ptr;
    logic [1:0]     inflight;

    logic           found;
    logic [1:0]     win;
    logic [1:0]     idx;
    logic [NCH-1:0] pending_next;

    function automatic logic [NCH-1:0] onehot(input logic [1:0] k);
        logic [NCH-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting at the pointer; candidates are the
    // registered pending flags, so requests of this cycle are not eligible.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int j = 0; j < NCH; j++) begin
            idx = ptr + j[1:0];
            if (!found && pending[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // A same-cycle request on the winning channel keeps it pending: the new
    // value has already replaced the one being sent and must go out later.
    always_comb begin
        pending_next = pending | req;
        if (frame_tick && found && !req[win])
            pending_next[win] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd        <= '0;
            grant      <= '0;
            done       <= '0;
            pending    <= '0;
            busy       <= 1'b0;
            ptr        <= '0;
            inflight   <= '0;
            shadow_rng <= '0;
            for (int i = 0; i < NCH; i++)
                shadow_data[i] <= '0;
        end else begin
            grant <= '0;
            done  <= '0;
            // cmd only moves here, at the end of the driver's last frame
            // cycle, so it is stable for the whole following frame.
            if (frame_tick) begin
                if (busy)
                    done <= onehot(inflight);
                busy <= found;
                if (found) begin
                    cmd      <= {win, shadow_rng[win], shadow_data[win]};
                    grant    <= onehot(win);
                    ptr      <= win + 2'd1;
                    inflight <= win;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (req[i]) begin
                    shadow_data[i] <= req_data[i*DW +: DW];
                    shadow_rng[i]  <= req_rng[i];
                end
            end
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_dac_ch_scheduler.sv
module tb_dac_ch_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_rng;
    logic [10:0] cmd;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic [3:0]  pending;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dac_ch_scheduler #(.NCH(4), .DW(8)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .req(req),
        .req_data(req_data), .req_rng(req_rng), .cmd(cmd), .grant(grant),
        .done(done), .pending(pending), .busy(busy)
    );

    // Reference model state (what the outputs should be after each edge)
    logic [7:0]  m_sd [4];
    logic [3:0]  m_sr;
    logic [3:0]  m_pend;
    int          m_ptr;
    int          m_infl;
    logic        m_busy;
    logic [10:0] m_cmd;
    logic [3:0]  m_grant;
    logic [3:0]  m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model(input logic r, input logic [3:0] rq, input logic [31:0] d,
                         input logic [3:0] rg, input logic t);
        int w;
        logic [1:0] w2;
        if (r) begin
            for (int i = 0; i < 4; i++) m_sd[i] = 8'h00;
            m_sr = 0; m_pend = 0; m_ptr = 0; m_infl = 0;
            m_busy = 0; m_cmd = 0; m_grant = 0; m_done = 0;
        end else begin
            m_grant = 0;
            m_done  = 0;
            if (t) begin
                if (m_busy) m_done[m_infl] = 1'b1;
                w = -1;
                for (int j = 0; j < 4; j++)
                    if (w < 0 && m_pend[(m_ptr + j) % 4]) w = (m_ptr + j) % 4;
                if (w >= 0) begin
                    w2 = w[1:0];
                    m_cmd = {w2, m_sr[w], m_sd[w]};
                    m_grant[w] = 1'b1;
                    m_pend[w] = 1'b0;
                    m_ptr = (w + 1) % 4;
                    m_busy = 1'b1;
                    m_infl = w;
                end else begin
                    m_busy = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (rq[i]) begin
                    m_sd[i]   = d[i*8 +: 8];
                    m_sr[i]   = rg[i];
                    m_pend[i] = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive, clock, update model, compare every output
    task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d,
                        input logic [3:0] rg, input logic t);
        rst = r; req = rq; req_data = d; req_rng = rg; frame_tick = t;
        @(posedge clk);
        #1;
        model(r, rq, d, rg, t);
        chk("cmd",     32'(cmd),     32'(m_cmd));
        chk("grant",   32'(grant),   32'(m_grant));
        chk("done",    32'(done),    32'(m_done));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("busy",    32'(busy),    32'(m_busy));
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  rq;
        logic [31:0] d;
        logic [3:0]  rg;
        logic        t;
        logic [10:0] e_cmd;
        logic [3:0]  e_grant;
        logic [3:0]  e_done;
        logic [3:0]  e_pend;
        logic        e_busy;
    } vec_t;

    vec_t vt [13];

    initial begin
        int gcnt;
        int ch3_at;
        rst = 1'b1; req = 0; req_data = 0; req_rng = 0; frame_tick = 0;

        // Hand-computed vectors: reset, single write, round-robin sweep
        vt[0]  = '{1, 4'b0000, 32'h0,        4'b0000, 0, 11'h000, 4'b0000, 4'b0000, 4'b0000, 0};
        vt[1]  = '{0, 4'b0100, 32'h0080_0000, 4'b0000, 0, 11'h000, 4'b0000, 4'b0000, 4'b0100, 0};
        vt[2]  = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h480, 4'b0100, 4'b0000, 4'b0000, 1};
        vt[3]  = '{0, 4'b0000, 32'h0,        4'b0000, 0, 11'h480, 4'b0000, 4'b0000, 4'b0000, 1};
        vt[4]  = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h480, 4'b0000, 4'b0100, 4'b0000, 0};
        vt[5]  = '{1, 4'b0000, 32'h0,        4'b0000, 0, 11'h000, 4'b0000, 4'b0000, 4'b0000, 0};
        vt[6]  = '{0, 4'b1111, 32'h4433_2211, 4'b1111, 0, 11'h000, 4'b0000, 4'b0000, 4'b1111, 0};
        vt[7]  = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h111, 4'b0001, 4'b0000, 4'b1110, 1};
        vt[8]  = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h322, 4'b0010, 4'b0001, 4'b1100, 1};
        vt[9]  = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h533, 4'b0100, 4'b0010, 4'b1000, 1};
        vt[10] = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h744, 4'b1000, 4'b0100, 4'b0000, 1};
        vt[11] = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h744, 4'b0000, 4'b1000, 4'b0000, 0};
        vt[12] = '{0, 4'b0000, 32'h0,        4'b0000, 1, 11'h744, 4'b0000, 4'b0000, 4'b0000, 0};

        for (int k = 0; k < 13; k++) begin
            step(vt[k].r, vt[k].rq, vt[k].d, vt[k].rg, vt[k].t);
            chk($sformatf("vec%0d_cmd", k),     32'(cmd),     32'(vt[k].e_cmd));
            chk($sformatf("vec%0d_grant", k),   32'(grant),   32'(vt[k].e_grant));
            chk($sformatf("vec%0d_done", k),    32'(done),    32'(vt[k].e_done));
            chk($sformatf("vec%0d_pending", k), 32'(pending), 32'(vt[k].e_pend));
            chk($sformatf("vec%0d_busy", k),    32'(busy),    32'(vt[k].e_busy));
        end

        // Coalescing: two writes to channel 1 before the tick, last one wins
        step(0, 4'b0010, 32'h0000_1000, 4'b0000, 0);
        step(0, 4'b0010, 32'h0000_2000, 4'b0000, 0);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        chk("coalesce_cmd",   32'(cmd),   32'h220);
        chk("coalesce_grant", 32'(grant), 32'h2);

        // Same-cycle collision on channel 0
        step(0, 4'b0001, 32'h0000_00AA, 4'b0000, 0);
        step(0, 4'b0001, 32'h0000_0055, 4'b0000, 1);
        chk("collide_cmd",  32'(cmd),        32'h0AA);
        chk("collide_pend", 32'(pending[0]), 32'h1);
        step(0, 4'b0000, 32'h0, 4'b0000, 0);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        chk("collide_cmd2", 32'(cmd), 32'h055);

        // Reset mid-frame with a frame in flight and pending=1010
        step(0, 4'b0100, 32'h0077_0000, 4'b0000, 1);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        step(0, 4'b1010, 32'h9900_3300, 4'b0000, 0);
        chk("pre_rst_pend", 32'(pending), 32'hA);
        chk("pre_rst_busy", 32'(busy),    32'h1);
        step(1, 4'b0000, 32'h0, 4'b0000, 0);
        chk("rst_cmd",  32'(cmd),     32'h000);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_busy", 32'(busy),    32'h0);
        step(0, 4'b0000, 32'h0, 4'b0000, 1);
        chk("rst_no_done", 32'(done), 32'h0);

        // Fairness: req[0] held high, req[3] pulsed once
        gcnt = 0;
        ch3_at = -1;
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(0, (f == 1 && c == 0) ? 4'b1001 : 4'b0001, 32'hC300_00A0, 4'b0000, c == 3);
                if (f >= 1 && grant != 0) begin
                    gcnt++;
                    if (grant[3] && ch3_at < 0) ch3_at = gcnt;
                end
            end
        end
        chk("fair_ch3_granted", 32'(ch3_at >= 1 && ch3_at <= 2), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 149) == 0,
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom, 4'($urandom),
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
